// File: rtl/rvfi_retire_buffer_pkg.sv
// Shared types for the RVFI retirement-trace buffer: the retire record and the buffer FSM state.
package rvfi_retire_buffer_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned RETIRE_NRET_MAX = 4;

  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic            trap;
  } retire_rec_t;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StHalted
  } rvfi_buf_state_e;

endpackage

// File: rtl/rvfi_retire_buffer_if.sv
// Retire-side and checker-side handshakes of the retirement-trace buffer.
interface rvfi_retire_buffer_if
  import rvfi_retire_buffer_pkg::*;
#(
  parameter int unsigned NRET    = 2,
  parameter int unsigned ORDER_W = 64
);

  logic [NRET-1:0]        in_valid;
  retire_rec_t [NRET-1:0] in_rec;
  logic                   in_ready;
  logic                   out_valid;
  logic                   out_ready;
  retire_rec_t            out_rec;
  logic [ORDER_W-1:0]     out_order;

  modport master (
    output in_valid, in_rec, out_ready,
    input  in_ready, out_valid, out_rec, out_order
  );

  modport slave (
    input  in_valid, in_rec, out_ready,
    output in_ready, out_valid, out_rec, out_order
  );

endinterface

// File: rtl/rvfi_fifo_mem.sv
// Record+order storage with NRET write ports and one registered read port.
// The read port bypasses same-cycle writes so a freshly pushed head is visible next cycle.
module rvfi_fifo_mem
  import rvfi_retire_buffer_pkg::*;
#(
  parameter int unsigned NRET    = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ORDER_W = 64,
  localparam int unsigned PtrW   = $clog2(DEPTH)
) (
  input  logic                          CLK,
  input  logic                          Reset_n,
  input  logic [NRET-1:0]               we,
  input  logic [NRET-1:0][PtrW-1:0]     waddr,
  input  retire_rec_t [NRET-1:0]        wrec,
  input  logic [NRET-1:0][ORDER_W-1:0]  word,
  input  logic [PtrW-1:0]               raddr,
  output retire_rec_t                   rrec,
  output logic [ORDER_W-1:0]            rord
);

  retire_rec_t        mem_rec [DEPTH];
  logic [ORDER_W-1:0] mem_ord [DEPTH];
  retire_rec_t        rrec_d;
  logic [ORDER_W-1:0] rord_d;

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NRET; i++) begin
      if (we[i]) begin
        mem_rec[waddr[i]] <= wrec[i];
        mem_ord[waddr[i]] <= word[i];
      end
    end
  end

  always_comb begin
    rrec_d = mem_rec[raddr];
    rord_d = mem_ord[raddr];
    for (int i = 0; i < NRET; i++) begin
      if (we[i] && (waddr[i] == raddr)) begin
        rrec_d = wrec[i];
        rord_d = word[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      rrec <= '0;
      rord <= '0;
    end else begin
      rrec <= rrec_d;
      rord <= rord_d;
    end
  end

endmodule

// File: rtl/rvfi_retire_buffer.sv
// Retirement-trace buffer: numbers up to NRET retired records per cycle, queues them and drains
// one per cycle; closes after a trapping instruction has been drained.
module rvfi_retire_buffer
  import rvfi_retire_buffer_pkg::*;
#(
  parameter int unsigned NRET    = 2,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ORDER_W = 64
) (
  input  logic                   CLK,
  input  logic                   Reset_n,
  rvfi_retire_buffer_if.slave    bus,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  rvfi_buf_state_e state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [ORDER_W-1:0] order_q, order_d;
  logic overflow_q, overflow_d;

  logic [CntW-1:0] n_keep, n_push;
  logic packed_ok, attempt, trap_hit, cut, push, pop;
  logic [NRET-1:0]               we;
  logic [NRET-1:0][PtrW-1:0]     waddr;
  retire_rec_t [NRET-1:0]        wrec;
  logic [NRET-1:0][ORDER_W-1:0]  word;

  assign bus.in_ready  = (state_q == StRun) && ((CntW'(DEPTH) - count_q) >= CntW'(NRET));
  assign bus.out_valid = (count_q != '0) && (state_q != StHalted);
  assign pop           = bus.out_valid && bus.out_ready;

  // Lane compaction: keep lanes up to and including the first trapping one.
  always_comb begin
    packed_ok = ((bus.in_valid & (bus.in_valid + NRET'(1))) == '0);
    attempt   = |bus.in_valid;
    n_keep    = '0;
    trap_hit  = 1'b0;
    cut       = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      wrec[i] = bus.in_rec[i];
      if (bus.in_rec[i].rd_addr == 5'd0) wrec[i].rd_wdata = '0;
      word[i]  = order_q + ORDER_W'(i);
      waddr[i] = wr_ptr_q + PtrW'(i);
      if (bus.in_valid[i] && !cut) begin
        n_keep = n_keep + CntW'(1);
        if (bus.in_rec[i].trap) begin
          trap_hit = 1'b1;
          cut      = 1'b1;
        end
      end
    end
    push   = attempt && packed_ok && bus.in_ready;
    n_push = push ? n_keep : '0;
    for (int i = 0; i < NRET; i++) begin
      we[i] = push && (CntW'(i) < n_keep);
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + n_push[PtrW-1:0];
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    count_d    = count_q + n_push - CntW'(pop);
    order_d    = order_q + ORDER_W'(n_push);
    // Pushes into a draining or halted buffer are expected and not an overflow.
    overflow_d = overflow_q | ((state_q == StRun) && attempt && (!packed_ok || !bus.in_ready));
    state_d    = state_q;
    unique case (state_q)
      StRun:    if (push && trap_hit) state_d = StDrain;
      StDrain:  if (count_d == '0) state_d = StHalted;
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StRun;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      order_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      order_q    <= order_d;
      overflow_q <= overflow_d;
    end
  end

  rvfi_fifo_mem #(
    .NRET    (NRET),
    .DEPTH   (DEPTH),
    .ORDER_W (ORDER_W)
  ) u_mem (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .we      (we),
    .waddr   (waddr),
    .wrec    (wrec),
    .word    (word),
    .raddr   (rd_ptr_d),
    .rrec    (bus.out_rec),
    .rord    (bus.out_order)
  );

  assign count    = count_q;
  assign overflow = overflow_q;
  assign halted   = (state_q == StHalted);

endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Scoreboard bench for rvfi_retire_buffer (NRET=2, DEPTH=16, ORDER_W=64).
module tb_rvfi_retire_buffer;
  import rvfi_retire_buffer_pkg::*;

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic [4:0] count;
  logic       overflow;
  logic       halted;

  rvfi_retire_buffer_if #(.NRET(2), .ORDER_W(64)) bus ();

  rvfi_retire_buffer #(
    .NRET    (2),
    .DEPTH   (16),
    .ORDER_W (64)
  ) dut (
    .CLK      (CLK),
    .Reset_n  (Reset_n),
    .bus      (bus.slave),
    .count    (count),
    .overflow (overflow),
    .halted   (halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] ord;
    logic [31:0] pc;
    logic [31:0] wd;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [63:0] model_order = '0;
  bit          closed = 1'b0;
  bit          exp_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic retire_rec_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                     input logic [31:0] wd, input logic trap);
    retire_rec_t r;
    r.insn     = 32'h0000_0013;
    r.pc_rdata = pc;
    r.pc_wdata = pc + 32'd4;
    r.rd_addr  = rd;
    r.rd_wdata = wd;
    r.trap     = trap;
    return r;
  endfunction

  // Called at posedge+1; drives one beat, models acceptance, returns at the next posedge+1.
  task automatic step(input logic [1:0] v, input retire_rec_t r0, input retire_rec_t r1,
                      input logic ordy);
    bit          ready_m;
    exp_t        e;
    retire_rec_t r [2];
    check_val("overflow", overflow, exp_ovf);
    ready_m = !closed && ((16 - sb.size()) >= 2);
    check_val("in_ready", bus.in_ready, ready_m);
    bus.in_valid  = v;
    bus.in_rec[0] = r0;
    bus.in_rec[1] = r1;
    bus.out_ready = ordy;
    r[0] = r0;
    r[1] = r1;
    if (v != 2'b00 && !closed) begin
      if (v == 2'b10 || !ready_m) begin
        exp_ovf = 1'b1;
      end else begin
        for (int i = 0; i < $countones(v); i++) begin
          e.ord = model_order;
          e.pc  = r[i].pc_rdata;
          e.wd  = (r[i].rd_addr == 5'd0) ? 32'd0 : r[i].rd_wdata;
          sb.push_back(e);
          model_order++;
          if (r[i].trap) begin
            closed = 1'b1;
            break;
          end
        end
      end
    end
    @(posedge CLK);
    #1;
    bus.in_valid = '0;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(2'b00, '0, '0, ordy);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (Reset_n && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check_val("sb_underrun", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        check_val("out_order", bus.out_order, e.ord);
        check_val("out_pc", 64'(bus.out_rec.pc_rdata), 64'(e.pc));
        check_val("out_wdata", 64'(bus.out_rec.rd_wdata), 64'(e.wd));
      end
    end
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_rec    = '0;
    bus.out_ready = 1'b0;
    #12;
    check_val("rst_count", 64'(count), 64'd0);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_halted", 64'(halted), 64'd0);
    check_val("rst_out_order", bus.out_order, 64'd0);
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;

    // Two lanes in one beat, drained over two pops.
    step(2'b11, mk(32'h0, 5'd1, 32'h11, 1'b0), mk(32'h4, 5'd2, 32'h22, 1'b0), 1'b1);
    check_val("t1_count2", 64'(count), 64'd2);
    idle(1, 1'b1);
    check_val("t1_count1", 64'(count), 64'd1);
    idle(1, 1'b1);
    check_val("t1_count0", 64'(count), 64'd0);

    // Fill to DEPTH, then one rejected beat.
    for (int i = 0; i < 8; i++) begin
      step(2'b11, mk(32'(32'h100 + i * 8), 5'd3, 32'(i), 1'b0),
           mk(32'(32'h104 + i * 8), 5'd4, 32'(i + 100), 1'b0), 1'b0);
    end
    check_val("fill_count", 64'(count), 64'd16);
    check_val("fill_in_ready", 64'(bus.in_ready), 64'd0);
    step(2'b11, mk(32'hBAD0, 5'd1, 32'h1, 1'b0), mk(32'hBAD4, 5'd1, 32'h2, 1'b0), 1'b0);
    check_val("ovf_set", 64'(overflow), 64'd1);
    check_val("ovf_count", 64'(count), 64'd16);
    idle(17, 1'b1);
    check_val("fill_drained", 64'(count), 64'd0);
    step(2'b01, mk(32'h200, 5'd6, 32'h66, 1'b0), '0, 1'b1);
    idle(2, 1'b1);

    // Reach count=5, then push+pop in the same cycle; then long wrap run.
    step(2'b11, mk(32'h300, 5'd1, 32'h1, 1'b0), mk(32'h304, 5'd1, 32'h2, 1'b0), 1'b0);
    step(2'b11, mk(32'h308, 5'd1, 32'h3, 1'b0), mk(32'h30c, 5'd1, 32'h4, 1'b0), 1'b0);
    step(2'b01, mk(32'h310, 5'd1, 32'h5, 1'b0), '0, 1'b0);
    check_val("sim_count5", 64'(count), 64'd5);
    step(2'b01, mk(32'h314, 5'd1, 32'h6, 1'b0), '0, 1'b1);
    check_val("sim_count_hold", 64'(count), 64'd5);
    for (int i = 0; i < 40; i++) begin
      step(2'b01, mk(32'(32'h400 + i * 4), 5'(i % 32), 32'(i * 3), 1'b0), '0, 1'b1);
    end
    check_val("wrap_count", 64'(count), 64'd5);
    idle(6, 1'b1);
    check_val("wrap_drained", 64'(count), 64'd0);

    // x0 squash vs preserved write data.
    step(2'b11, mk(32'h500, 5'd0, 32'hDEADBEEF, 1'b0), mk(32'h504, 5'd5, 32'hDEADBEEF, 1'b0),
         1'b1);
    idle(3, 1'b1);

    // Non-packed valid mask is dropped and flagged.
    step(2'b10, '0, mk(32'h600, 5'd1, 32'h1, 1'b0), 1'b1);
    idle(1, 1'b1);
    check_val("gap_count", 64'(count), 64'd0);

    // Asynchronous reset with seven entries queued.
    step(2'b11, mk(32'h700, 5'd1, 32'h1, 1'b0), mk(32'h704, 5'd1, 32'h2, 1'b0), 1'b0);
    step(2'b11, mk(32'h708, 5'd1, 32'h3, 1'b0), mk(32'h70c, 5'd1, 32'h4, 1'b0), 1'b0);
    step(2'b11, mk(32'h710, 5'd1, 32'h5, 1'b0), mk(32'h714, 5'd1, 32'h6, 1'b0), 1'b0);
    step(2'b01, mk(32'h718, 5'd1, 32'h7, 1'b0), '0, 1'b0);
    check_val("pre_rst_count", 64'(count), 64'd7);
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_count", 64'(count), 64'd0);
    check_val("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("arst_overflow", 64'(overflow), 64'd0);
    sb.delete();
    model_order = '0;
    closed      = 1'b0;
    exp_ovf     = 1'b0;
    #2;
    Reset_n = 1'b1;
    @(posedge CLK);
    #1;
    step(2'b01, mk(32'h800, 5'd7, 32'h77, 1'b0), '0, 1'b1);
    idle(2, 1'b1);
    check_val("post_rst_count", 64'(count), 64'd0);

    // Trap in lane 0 discards lane 1, drains, then halts.
    step(2'b11, mk(32'h900, 5'd1, 32'h9, 1'b1), mk(32'h904, 5'd2, 32'hA, 1'b0), 1'b0);
    check_val("trap_count", 64'(count), 64'd1);
    step(2'b11, mk(32'h908, 5'd1, 32'hB, 1'b0), mk(32'h90c, 5'd2, 32'hC, 1'b0), 1'b0);
    check_val("drain_count", 64'(count), 64'd1);
    check_val("drain_no_ovf", 64'(overflow), 64'd0);
    idle(3, 1'b1);
    check_val("halted", 64'(halted), 64'd1);
    check_val("halt_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("halt_count", 64'(count), 64'd0);
    check_val("sb_left", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rvfi_retire_buffer.md
Name: rvfi_retire_buffer

Overview:
- Parametrised retirement-trace buffer that sits between one or more core retire ports and the RVFI checker/logger.
- Accepts up to NRET retired-instruction records per cycle and assigns each a monotonically increasing order number. Stores records in a circular FIFO and drains one record per cycle over a valid/ready handshake.
- Adds overflow detection, RVFI x0 write-data squashing, and trap-halt sequencing.

Parameters:
- XLEN, 32, data/address width of all record fields.
- NRET, 2, retire lanes accepted per cycle (1..4).
- DEPTH, 16, FIFO entries; power of two, DEPTH >= 2*NRET.
- ORDER_W, 64, width of the order counter.

Ports:
- CLK  input  1  clock, rising edge.
- Reset_n  input  1  reset, asynchronous, active-low.
- in_valid  input  NRET  per-lane retire valid; lanes packed from lane 0 (no gaps).
- in_rec  input  NRET x retire_rec_t  per-lane record: insn, pc_rdata, pc_wdata, rd_addr, rd_wdata, trap.
- in_ready  output  1  buffer can accept NRET records this cycle.
- out_valid  output  1  head record available.
- out_ready  input  1  consumer takes head record.
- out_rec  output  retire_rec_t  head record.
- out_order  output  ORDER_W  order number of head record.
- count  output  $clog2(DEPTH)+1  occupied entries.
- overflow  output  1  sticky; a push was attempted while in_ready=0.
- halted  output  1  trap drained; buffer closed.

Behaviour:
- Reset (async, Reset_n=0):
  - Pointers, count and order counter go to 0; overflow=0; halted=0; state RUN.
  - out_valid=0, in_ready=1, out_rec/out_order=0.
- Push:
  - k = popcount(in_valid).
  - Push occurs when k>0 and in_ready=1. Lane i is written to slot wr_ptr+i (mod DEPTH) with order = order_cnt+i.
  - wr_ptr += k, order_cnt += k. Both wrap modulo DEPTH and 2^ORDER_W.
- Non-packed in_valid (e.g. 2'b10) is illegal: the buffer ignores the whole beat and sets overflow.
- in_ready = (DEPTH - count >= NRET) and state==RUN. It is computed from registered state only, with no combinational path from out_ready.
- Push attempted while in_ready=0: records are dropped, order_cnt is unchanged, overflow=1 until reset.
- x0 squash: any lane with rd_addr==0 is stored with rd_wdata=0.
- Pop:
  - out_valid = (count>0). The head is registered, so records appear one cycle after push at the earliest.
  - On out_valid & out_ready, rd_ptr increments.
  - out_rec/out_order hold stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: count += k-1 in the same cycle. Full-to-non-full and empty-to-non-empty transitions are exact, with no lost or duplicated slot.
- FSM states:
  - RUN: normal. If any pushed lane has trap=1, lanes above the first trapping lane are discarded and not counted, and the state goes to DRAIN.
  - DRAIN: in_ready=0, and push attempts are ignored without raising overflow. Pops continue. When count reaches 0 (pop of the last entry), go to HALTED.
  - HALTED: halted=1, in_ready=0, out_valid=0. Leaves only via reset.
- Reset mid-operation: all contents are discarded immediately; the first record after reset gets order 0.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are decided by count, not by pointer equality.

Decomposition:
- RISCV_PKG gains:
  - retire_rec_t packed struct (insn[31:0], pc_rdata/pc_wdata/rd_wdata[XLEN-1:0], rd_addr[4:0], trap).
  - RETIRE_NRET_MAX=4 constant.
  - rvfi_buf_state_e enum {RUN, DRAIN, HALTED}.
- One sub-module, rvfi_fifo_mem: DEPTH x (record+order) storage with NRET write ports and one registered read port, no reset on the array.
- FSM, counters, lane compaction and squash logic live in the top.

Test Plan:
- Reset release, NRET=2: push lanes 2'b11 with pc_rdata 0x0/0x4 -> out_order 0 then 1, pc_rdata 0x0 then 0x4, count 2->0 over two pops with out_ready=1.
- Fill: hold out_ready=0, push 2'b11 eight times at DEPTH=16 -> count=16, in_ready=0. Ninth push -> overflow=1, count stays 16, next accepted order = 16.
- Simultaneous push of 2'b01 and pop at count=5 -> count stays 5. Pointer wrap after 40 push/pop cycles -> orders strictly consecutive, no gaps.
- rd_addr=0 with rd_wdata=0xDEADBEEF -> out_rec.rd_wdata=0. rd_addr=5 -> 0xDEADBEEF preserved.
- Push 2'b11 with lane0 trap=1 -> only lane0 stored (order N). in_ready=0 next cycle; after the final pop, halted=1 and out_valid=0.
- Assert Reset_n=0 asynchronously mid-stream with count=7 -> count=0, out_valid=0 without a clock edge. After release, the first pushed record gets order 0.
